// File: rtl/bus_controller.sv
// -----------------------------------------------------------------------------
// bus_controller
//   68000 glue logic for the system CPLD. It decodes ADDR/FC into chip selects
//   and generates DTACK with a per-region wait-state count. For the first
//   BOOT_CYCLES bus cycles after reset it overlays the boot ROM on every
//   non-IACK address. It also encodes up to seven interrupt requests onto IPL
//   and answers IACK cycles either with a vectored acknowledge or an
//   autovector request.
//
//   Optional feature macro: BUS_CONTROLLER_WATCHDOG_EN
//     defined   : an 8-bit watchdog raises BERR when a cycle stays unanswered.
//     undefined : BERR is tied high, and an unmatched access hangs the bus.
//
// Ports
//   CLK, RST              clock; synchronous reset, active low
//   ADDR[23:1]            CPU address bus
//   AS, UDS, LDS          CPU strobes, active low
//   RW                    1 = read (not needed for decode)
//   FC[2:0]               function code; 3'b111 = CPU space / IACK
//   IRQ_N[N_IRQ-1:0]      interrupt requests, active low; bit i is level i+1
//   DTACK_EXT             acknowledge from IO/EXP devices, active low
//   ROM/RAM/IO/EXP_CS_N   chip selects, active low
//   DTACK, BERR, VPA      CPU cycle terminations, active low
//   IPL[2:0]              active-low interrupt priority level to the CPU
//   IACK_N                vectored interrupt acknowledge, active low
//   BOOT_DONE             high once the boot overlay has finished
//   state_dbg_o[1:0]      current bus FSM state, for observation
//
// Bus handshake:
//   AS low opens a cycle. The controller answers exactly once, with DTACK,
//   VPA or BERR. It holds that answer until AS returns high. On the clock
//   edge that samples AS high, every termination drops and the FSM goes
//   back to IDLE.
// -----------------------------------------------------------------------------
module bus_controller #(
  parameter int         N_IRQ       = 7,
  parameter logic [6:0] VEC_MASK    = 7'h01,
  parameter int         BOOT_CYCLES = 4,
  parameter logic [3:0] ROM_BASE    = 4'hE,
  parameter logic [3:0] IO_BASE     = 4'hC,
  parameter logic [3:0] RAM_TOP     = 4'h1,
  parameter logic [3:0] EXP_TOP     = 4'h9,
  parameter int         ROM_WAIT    = 2,
  parameter int         RAM_WAIT    = 0,
  parameter int         BERR_CYCLES = 255
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [23:1]      ADDR,
  input  logic             AS,
  input  logic             UDS,
  input  logic             LDS,
  input  logic             RW,
  input  logic [2:0]       FC,
  input  logic [N_IRQ-1:0] IRQ_N,
  input  logic             DTACK_EXT,
  output logic             ROM_CS_N,
  output logic             RAM_CS_N,
  output logic             IO_CS_N,
  output logic             EXP_CS_N,
  output logic             DTACK,
  output logic             BERR,
  output logic             VPA,
  output logic [2:0]       IPL,
  output logic             IACK_N,
  output logic             BOOT_DONE,
  output logic [1:0]       state_dbg_o
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_BERR} state_t;
  typedef enum logic [2:0] {R_NONE, R_ROM, R_RAM, R_IO, R_EXP, R_IACK} region_t;

  localparam int BOOT_W = (BOOT_CYCLES < 2) ? 1 : $clog2(BOOT_CYCLES + 1);
  // VEC_BY_LVL[L] is the vector-mask bit for interrupt level L. Bit 0 is unused.
  localparam logic [7:0] VEC_BY_LVL = {VEC_MASK, 1'b0};
  // The entry edge already counts as one cycle, so the preload is one less
  // than the wait count. This keeps the total latency at WAIT+1 edges.
  localparam logic [3:0] ROM_LOAD = (ROM_WAIT > 0) ? 4'(ROM_WAIT - 1) : 4'd0;
  localparam logic [3:0] RAM_LOAD = (RAM_WAIT > 0) ? 4'(RAM_WAIT - 1) : 4'd0;

  state_t              state_q, state_d;
  logic [3:0]          wcnt_q, wcnt_d;
  logic [BOOT_W-1:0]   boot_q, boot_d;
  logic                boot_done_q, boot_done_d;
  logic [2:0]          ipl_q, ipl_d;
  logic                as_q;
  region_t             region;
  logic                iack_vec, iack_auto, start, any_ds;
  logic [2:0]          irq_lvl;

  // Decode the region from the current address and function code.
  always_comb begin
    region = R_NONE;
    if (FC == 3'b111) begin
      if (ADDR[3:1] != 3'd0 && {29'd0, ADDR[3:1]} <= 32'(N_IRQ)) region = R_IACK;
    end else if (!boot_done_q) begin
      region = R_ROM;
    end else if (ADDR[23:20] == ROM_BASE) begin
      region = R_ROM;
    end else if (ADDR[23:20] == IO_BASE) begin
      region = R_IO;
    end else if (ADDR[23:20] < RAM_TOP) begin
      region = R_RAM;
    end else if (ADDR[23:20] < EXP_TOP) begin
      region = R_EXP;
    end
  end

  assign iack_vec  = (region == R_IACK) &&  VEC_BY_LVL[ADDR[3:1]];
  assign iack_auto = (region == R_IACK) && !VEC_BY_LVL[ADDR[3:1]];
  assign any_ds    = !UDS || !LDS;
  // A cycle starts only on a fresh AS assertion. If a reset arrives while
  // AS is held low, the cycle is abandoned until the CPU releases AS.
  assign start     = !AS && as_q;

  assign ROM_CS_N = !(!AS && region == R_ROM && any_ds);
  assign RAM_CS_N = !(!AS && region == R_RAM && any_ds);
  assign IO_CS_N  = !(!AS && region == R_IO && !LDS);
  assign EXP_CS_N = !(!AS && region == R_EXP);
  assign IACK_N   = !(!AS && iack_vec);

`ifdef BUS_CONTROLLER_WATCHDOG_EN
  logic [7:0] wd_q, wd_d;
`endif

  // Bus FSM next state.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      S_IDLE: begin
        wcnt_d = 4'd0;
        if (start) begin
          state_d = S_WAIT;
          if (region == R_ROM) begin
            if (ROM_WAIT == 0) state_d = S_ACK;
            else wcnt_d = ROM_LOAD;
          end else if (region == R_RAM) begin
            if (RAM_WAIT == 0) state_d = S_ACK;
            else wcnt_d = RAM_LOAD;
          end
        end
      end
      S_WAIT: begin
        if (AS) begin
          state_d = S_IDLE;
        end else begin
          case (region)
            R_ROM, R_RAM: begin
              if (wcnt_q == 4'd0) state_d = S_ACK;
              else wcnt_d = wcnt_q - 4'd1;
            end
            R_IO, R_EXP: if (!DTACK_EXT) state_d = S_ACK;
            R_IACK:      if (iack_auto || !DTACK_EXT) state_d = S_ACK;
            default: ;  // unmatched: only the watchdog can end it
          endcase
        end
      end
      S_ACK, S_BERR: if (AS) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
`ifdef BUS_CONTROLLER_WATCHDOG_EN
    // The start edge is the first tick, so BERR lands BERR_CYCLES edges
    // after AS is first seen low. An acknowledge in the same edge wins.
    wd_d = wd_q;
    if (state_q == S_IDLE) begin
      wd_d = start ? 8'd1 : 8'd0;
    end else if (state_q == S_WAIT) begin
      wd_d = wd_q + 8'd1;
      if (state_d == S_WAIT && wd_d == 8'(BERR_CYCLES)) state_d = S_BERR;
    end
`endif
  end

  // The boot overlay counts completed cycles, marked by AS rising.
  always_comb begin
    boot_d      = boot_q;
    boot_done_d = boot_done_q;
    if (AS && !as_q && !boot_done_q) begin
      boot_d = boot_q + BOOT_W'(1);
      if (boot_d == BOOT_W'(BOOT_CYCLES)) boot_done_d = 1'b1;
    end
  end

  // The highest requesting level wins.
  always_comb begin
    irq_lvl = 3'd0;
    for (int i = 0; i < N_IRQ; i++) begin
      if (!IRQ_N[i]) irq_lvl = 3'(i + 1);
    end
    ipl_d = ~irq_lvl;
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q     <= S_IDLE;
      wcnt_q      <= 4'd0;
      boot_q      <= '0;
      boot_done_q <= 1'b0;
      ipl_q       <= 3'b111;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      boot_q      <= boot_d;
      boot_done_q <= boot_done_d;
      ipl_q       <= ipl_d;
    end
  end

  // AS is tracked through reset as well. This stops a strobe still low at
  // reset release from looking like a new cycle, and stops AS held high from
  // being counted as a rising edge.
  always_ff @(posedge CLK) as_q <= AS;

`ifdef BUS_CONTROLLER_WATCHDOG_EN
  always_ff @(posedge CLK) begin
    if (!RST) wd_q <= 8'd0;
    else      wd_q <= wd_d;
  end
  assign BERR = !(state_q == S_BERR);
`else
  assign BERR = 1'b1;
`endif

  assign DTACK       = !(state_q == S_ACK && !iack_auto);
  assign VPA         = !(state_q == S_ACK &&  iack_auto);
  assign IPL         = ipl_q;
  assign BOOT_DONE   = boot_done_q;
  assign state_dbg_o = state_q;

  logic unused_ok;
  assign unused_ok = ^{RW, ADDR[19:4]};

endmodule
